uart_pwm_frame_parser: RTL and testbench
========================================

UART_PWM_FRAME_PARSER -- requirements
Module: uart_pwm_frame_parser

Interface
REQ-001 Parameter TIMEOUT_CYC, default 10000, inter-byte timeout in sys_clk cycles (about 2.3 byte times at 50 MHz / 115200 baud).
REQ-002 Parameter HDR_BYTE, default 8'h55, frame header value.
REQ-003 Parameter FTR_BYTE, default 8'hAA, frame footer value.
REQ-004 sys_clk  input  1  single clock domain; every register is clocked on its rising edge.
REQ-005 sys_rst_n  input  1  asynchronous active-low reset: assertion takes effect immediately, release is sampled on sys_clk.
REQ-006 rx_data  input  8  received byte from the UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe marking rx_data valid.
REQ-008 cfg_valid  output  1  one-cycle pulse when a good frame has been decoded.
REQ-009 cfg_reg_func  output  8  frame byte 2.
REQ-010 cfg_ch  output  8  frame byte 3, PWM channel.
REQ-011 cfg_ctrl_sta  output  8  frame byte 4, enable/control.
REQ-012 cfg_duty_num  output  8  frame byte 5.
REQ-013 cfg_pulse_dessert  output  16  {byte 6, byte 7}.
REQ-014 cfg_pulse_num  output  8  frame byte 8.
REQ-015 cfg_pat  output  32  {byte 9, 10, 11, 12}; byte 9 is the MSB.
REQ-016 crc_err  output  1  one-cycle pulse: footer correct, CRC mismatch.
REQ-017 frame_err  output  1  one-cycle pulse: wrong footer or timeout.

Function
REQ-018 Frame layout is 14 bytes: HDR, 11 payload bytes (bytes 2-12), CRC, FTR.
REQ-019 CRC rule: CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over payload bytes 2-12 only.
REQ-020 CRC is updated bytewise in the same cycle as the rx_valid that delivers the byte.
REQ-021 States: IDLE, PAYLOAD, CRC_CHK, FOOTER.
REQ-022 IDLE: rx_valid with rx_data==HDR_BYTE -> PAYLOAD, byte index 0, CRC cleared; any other byte is discarded silently.
REQ-023 PAYLOAD: each rx_valid stores the byte into a shadow register at the current index; at index 10 -> CRC_CHK.
REQ-024 A byte equal to HDR_BYTE inside PAYLOAD or CRC_CHK is treated as data; parsing does not resync.
REQ-025 CRC_CHK: the next rx_valid byte is compared with the computed CRC, the match flag is latched, -> FOOTER.
REQ-026 FOOTER, byte==FTR_BYTE with CRC match: shadow copied to the cfg_* outputs and cfg_valid=1 in the cycle after the footer rx_valid (latency 1), -> IDLE.
REQ-027 FOOTER, byte==FTR_BYTE with CRC mismatch: crc_err=1 for one cycle, cfg_* unchanged, -> IDLE.
REQ-028 FOOTER, byte!=FTR_BYTE: frame_err=1 for one cycle, cfg_* unchanged, -> IDLE (regardless of CRC result).
REQ-029 Timeout: in any state other than IDLE, a counter counts cycles since the last rx_valid.
REQ-030 Reaching TIMEOUT_CYC-1 without a byte: frame_err=1 for one cycle, -> IDLE, shadow discarded.
REQ-031 The timeout counter is cleared on every rx_valid and held at 0 in IDLE.
REQ-032 rx_valid arriving in the cycle the timeout fires is ignored, and IDLE is entered.
REQ-033 cfg_valid, crc_err and frame_err are mutually exclusive, and each lasts exactly one cycle.
REQ-034 cfg_* outputs hold their last good frame indefinitely; only a good frame updates them.
REQ-035 The block accepts back-to-back frames: a header arriving the cycle after the footer is accepted.

Reset
REQ-036 On sys_rst_n low: state=IDLE, byte index=0, CRC=0x00, timeout counter=0, shadow registers=0.
REQ-037 On sys_rst_n low: all cfg_* outputs=0, and cfg_valid, crc_err and frame_err=0.
REQ-038 Reset asserted mid-frame abandons the frame with no error pulse; a frame starting after release parses normally.

Verification
REQ-039 Good frame 55 01 00 00 00 00 00 00 00 00 00 00 1F AA -> one cfg_valid the cycle after AA; cfg_reg_func=01, all other cfg_*=0, no error pulses.
REQ-040 Same frame with CRC byte 1E -> crc_err pulse only; cfg_* keep their prior values.
REQ-041 Same frame with footer 55 -> frame_err pulse only; the following good frame is decoded.
REQ-042 Header plus 5 bytes, then line idle longer than TIMEOUT_CYC cycles -> a single frame_err pulse, return to IDLE, and the next good frame is accepted.
REQ-043 Garbage bytes 00 FF 12 before a good frame -> garbage ignored, exactly one cfg_valid.
REQ-044 Frame with cfg_pat bytes 12 34 56 78 and pulse_dessert bytes AB CD, CRC from the bench model -> cfg_pat=32'h12345678, cfg_pulse_dessert=16'hABCD.
REQ-045 Reset pulse after byte 7 of a frame -> no pulses; all outputs are 0 after reset.

Source files
------------

// File: rtl/uart_pwm_frame_parser.sv
// Parses 14-byte UART frames (HDR, 11 payload bytes, CRC-8, FTR) into PWM configuration registers.
// Bad CRC, bad footer and inter-byte timeout each produce a one-cycle error pulse.
module uart_pwm_frame_parser #(
    parameter int         TIMEOUT_CYC = 10000,
    parameter logic [7:0] HDR_BYTE    = 8'h55,
    parameter logic [7:0] FTR_BYTE    = 8'hAA
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cfg_valid,
    output logic [7:0]  cfg_reg_func,
    output logic [7:0]  cfg_ch,
    output logic [7:0]  cfg_ctrl_sta,
    output logic [7:0]  cfg_duty_num,
    output logic [15:0] cfg_pulse_dessert,
    output logic [7:0]  cfg_pulse_num,
    output logic [31:0] cfg_pat,
    output logic        crc_err,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC_CHK = 2'd2,
        ST_FOOTER  = 2'd3
    } state_t;

    // CRC-8, poly 0x07, MSB first, one byte per call
    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    state_t        r_state;
    state_t        w_state_nx;
    logic [3:0]    r_idx;
    logic [7:0]    r_crc;
    logic          r_crc_ok;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_shadow [0:10];
    logic          w_timeout;
    logic          w_accept;
    logic          w_load;
    logic          w_crc_err;
    logic          w_frame_err;
    logic [7:0]    w_crc_nx;

    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_accept  = rx_valid && !w_timeout;
    assign w_crc_nx  = crc8_upd(r_crc, rx_data);

    // Next-state and result-strobe decode; timeout wins over a byte arriving in the same cycle
    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_crc_err   = 1'b0;
        w_frame_err = 1'b0;
        if (w_timeout) begin
            w_state_nx  = ST_IDLE;
            w_frame_err = 1'b1;
        end else if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == HDR_BYTE) w_state_nx = ST_PAYLOAD;
                    else                     w_state_nx = ST_IDLE;
                end
                ST_PAYLOAD: begin
                    if (r_idx == 4'd10) w_state_nx = ST_CRC_CHK;
                    else                w_state_nx = ST_PAYLOAD;
                end
                ST_CRC_CHK: w_state_nx = ST_FOOTER;
                ST_FOOTER: begin
                    w_state_nx = ST_IDLE;
                    if (rx_data != FTR_BYTE) w_frame_err = 1'b1;
                    else if (r_crc_ok)       w_load      = 1'b1;
                    else                     w_crc_err   = 1'b1;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nx;
    end

    // Inter-byte timeout counter: idle-held, cleared by each byte
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                                      r_to_cnt <= '0;
        else if (w_timeout || rx_valid || r_state == ST_IDLE) r_to_cnt <= '0;
        else                                                 r_to_cnt <= r_to_cnt + TW'(1);
    end

    // Byte index, running CRC, CRC match flag and payload shadow
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_idx    <= 4'd0;
            r_crc    <= 8'h00;
            r_crc_ok <= 1'b0;
            for (int i = 0; i < 11; i++) r_shadow[i] <= 8'h00;
        end else if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == HDR_BYTE) begin
                        r_idx <= 4'd0;
                        r_crc <= 8'h00;
                    end
                end
                ST_PAYLOAD: begin
                    r_shadow[r_idx] <= rx_data;
                    r_crc           <= w_crc_nx;
                    r_idx           <= r_idx + 4'd1;
                end
                ST_CRC_CHK: r_crc_ok <= (rx_data == r_crc);
                default:    r_crc_ok <= r_crc_ok;
            endcase
        end
    end

    // Registered configuration outputs and result pulses
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cfg_valid         <= 1'b0;
            crc_err           <= 1'b0;
            frame_err         <= 1'b0;
            cfg_reg_func      <= 8'h00;
            cfg_ch            <= 8'h00;
            cfg_ctrl_sta      <= 8'h00;
            cfg_duty_num      <= 8'h00;
            cfg_pulse_dessert <= 16'h0000;
            cfg_pulse_num     <= 8'h00;
            cfg_pat           <= 32'h0000_0000;
        end else begin
            cfg_valid <= w_load;
            crc_err   <= w_crc_err;
            frame_err <= w_frame_err;
            if (w_load) begin
                cfg_reg_func      <= r_shadow[0];
                cfg_ch            <= r_shadow[1];
                cfg_ctrl_sta      <= r_shadow[2];
                cfg_duty_num      <= r_shadow[3];
                cfg_pulse_dessert <= {r_shadow[4], r_shadow[5]};
                cfg_pulse_num     <= r_shadow[6];
                cfg_pat           <= {r_shadow[7], r_shadow[8], r_shadow[9], r_shadow[10]};
            end
        end
    end

endmodule

// File: tb/tb_uart_pwm_frame_parser.sv
// Self-checking bench: directed frame table, hand-written corner sequences and randomized
// frames scored against a payload-level model (CRC by polynomial long division).
module tb_uart_pwm_frame_parser;

    localparam int TC = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        cfg_valid, crc_err, frame_err;
    logic [7:0]  cfg_reg_func, cfg_ch, cfg_ctrl_sta, cfg_duty_num, cfg_pulse_num;
    logic [15:0] cfg_pulse_dessert;
    logic [31:0] cfg_pat;

    uart_pwm_frame_parser #(.TIMEOUT_CYC(TC), .HDR_BYTE(8'h55), .FTR_BYTE(8'hAA)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cfg_valid(cfg_valid), .cfg_reg_func(cfg_reg_func), .cfg_ch(cfg_ch),
        .cfg_ctrl_sta(cfg_ctrl_sta), .cfg_duty_num(cfg_duty_num),
        .cfg_pulse_dessert(cfg_pulse_dessert), .cfg_pulse_num(cfg_pulse_num),
        .cfg_pat(cfg_pat), .crc_err(crc_err), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;
    int mon_v = 0, mon_c = 0, mon_f = 0;
    int s_v, s_c, s_f;
    logic p_v = 1'b0, p_c = 1'b0, p_f = 1'b0;
    logic [87:0] mdl_cfg;

    wire [87:0] w_cfg_all = {cfg_reg_func, cfg_ch, cfg_ctrl_sta, cfg_duty_num,
                             cfg_pulse_dessert, cfg_pulse_num, cfg_pat};

    // Pulse monitor: counts pulses, checks exclusivity and single-cycle width
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (cfg_valid || crc_err || frame_err) begin
                n_cmp++;
                if ((int'(cfg_valid) + int'(crc_err) + int'(frame_err)) > 1 ||
                    (cfg_valid && p_v) || (crc_err && p_c) || (frame_err && p_f)) begin
                    n_err++;
                    $display("FAIL pulse_shape: got v/c/f=%b%b%b prev=%b%b%b, need one single-cycle pulse",
                             cfg_valid, crc_err, frame_err, p_v, p_c, p_f);
                end
            end
            mon_v += int'(cfg_valid);
            mon_c += int'(crc_err);
            mon_f += int'(frame_err);
        end
        p_v = cfg_valid; p_c = crc_err; p_f = frame_err;
    end

    function automatic logic [7:0] crc_model(input logic [87:0] msg);
        logic [95:0] r;
        r = {msg, 8'h00};
        for (int i = 95; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bytes(input logic [111:0] fr, input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            send(fr[111 - 8*i -: 8]);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic snap();
        s_v = mon_v; s_c = mon_c; s_f = mon_f;
    endtask

    task automatic expect_res(input string tag, input int ev, input int ec, input int ef);
        idle(3);
        chk({tag, "_valid"}, 96'(mon_v - s_v), 96'(ev));
        chk({tag, "_crcerr"}, 96'(mon_c - s_c), 96'(ec));
        chk({tag, "_frmerr"}, 96'(mon_f - s_f), 96'(ef));
        chk({tag, "_cfg"}, 96'(w_cfg_all), 96'(mdl_cfg));
    endtask

    typedef struct {
        logic [111:0] fr;
        bit           fix_crc;
        int           ev, ec, ef;
        logic [87:0]  exp_cfg;
    } vec_t;

    vec_t tbl[4];
    logic [111:0] f0, f3, fr;
    logic [87:0]  pl;
    logic [7:0]   b;

    initial begin
        f0 = {8'h55, 8'h01, 80'h0, 8'h1F, 8'hAA};
        f3 = {8'h55, 88'h02_03_01_80_ABCD_05_12345678, 8'h00, 8'hAA};
        f3[15:8] = crc_model(f3[103:16]);
        tbl[0] = '{f0, 1'b0, 1, 0, 0, {8'h01, 80'h0}};
        tbl[1] = '{{8'h55, 8'h01, 80'h0, 8'h1E, 8'hAA}, 1'b0, 0, 1, 0, {8'h01, 80'h0}};
        tbl[2] = '{{8'h55, 8'h01, 80'h0, 8'h1F, 8'h55}, 1'b0, 0, 0, 1, {8'h01, 80'h0}};
        tbl[3] = '{{8'h55, 88'h02_03_01_80_ABCD_05_12345678, 8'h00, 8'hAA}, 1'b1, 1, 0, 0,
                   88'h02_03_01_80_ABCD_05_12345678};

        sys_rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        mdl_cfg = '0;
        idle(3);
        chk("reset_cfg", 96'(w_cfg_all), 96'h0);
        chk("reset_pulses", 96'({cfg_valid, crc_err, frame_err}), 96'h0);
        sys_rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 4; i++) begin
            fr = tbl[i].fr;
            if (tbl[i].fix_crc) fr[15:8] = crc_model(fr[103:16]);
            snap();
            send_bytes(fr, 14, 0);
            mdl_cfg = tbl[i].exp_cfg;
            expect_res($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].ef);
        end
        chk("pat_12345678", 96'(cfg_pat), 96'h12345678);
        chk("dessert_ABCD", 96'(cfg_pulse_dessert), 96'hABCD);

        // Exact latency of cfg_valid after footer
        send_bytes(f0, 13, 0);
        send(8'hAA);
        chk("lat_valid_hi", 96'(cfg_valid), 96'h1);
        idle(1);
        chk("lat_valid_lo", 96'(cfg_valid), 96'h0);
        mdl_cfg = {8'h01, 80'h0};

        // Garbage before a good frame
        snap();
        send(8'h00); send(8'hFF); send(8'h12);
        send_bytes(f3, 14, 0);
        mdl_cfg = f3[103:16];
        expect_res("garbage", 1, 0, 0);

        // Truncated frame followed by a long idle, then a good frame
        snap();
        send_bytes(f0, 6, 0);
        idle(TC + 10);
        expect_res("timeout", 0, 0, 1);
        snap();
        send_bytes(f0, 14, 0);
        mdl_cfg = f0[103:16];
        expect_res("after_to", 1, 0, 0);

        // Timeout boundary: byte at TC-1 cycles accepted, byte at TC cycles ignored
        snap();
        send_bytes(f3, 4, 0);
        idle(TC - 2);
        send(8'h01);
        chk("to_edge_ok", 96'(mon_f - s_f), 96'h0);
        idle(TC - 1);
        send(8'h55);
        expect_res("to_edge_fire", 0, 0, 1);
        snap();
        send_bytes(f3, 14, 0);
        mdl_cfg = f3[103:16];
        expect_res("after_edge", 1, 0, 0);

        // Back-to-back frames
        snap();
        send_bytes(f0, 14, 0);
        send_bytes(f3, 14, 0);
        mdl_cfg = f3[103:16];
        expect_res("b2b", 2, 0, 0);

        // Reset after byte 7 of a frame
        snap();
        send_bytes(f0, 7, 0);
        sys_rst_n = 1'b0;
        idle(2);
        chk("rst_mid_cfg", 96'(w_cfg_all), 96'h0);
        chk("rst_mid_pulses", 96'({cfg_valid, crc_err, frame_err}), 96'h0);
        sys_rst_n = 1'b1;
        mdl_cfg = '0;
        expect_res("rst_mid", 0, 0, 0);
        snap();
        send_bytes(f0, 14, 0);
        mdl_cfg = f0[103:16];
        expect_res("after_rst", 1, 0, 0);

        // Randomized frames against the payload-level model
        for (int it = 0; it < 40; it++) begin
            int kind, gap, ng;
            pl   = {$urandom, $urandom, 24'($urandom)};
            kind = int'($urandom_range(0, 3));
            gap  = int'($urandom_range(0, 2));
            ng   = int'($urandom_range(0, 2));
            fr   = {8'h55, pl, crc_model(pl), 8'hAA};
            snap();
            for (int g = 0; g < ng; g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h56;
                send(b);
            end
            case (kind)
                0: begin
                    send_bytes(fr, 14, gap);
                    mdl_cfg = pl;
                    expect_res($sformatf("rnd%0d_good", it), 1, 0, 0);
                end
                1: begin
                    fr[15:8] = fr[15:8] ^ 8'($urandom_range(1, 255));
                    send_bytes(fr, 14, gap);
                    expect_res($sformatf("rnd%0d_crc", it), 0, 1, 0);
                end
                2: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hAA) b = 8'hAB;
                    fr[7:0] = b;
                    send_bytes(fr, 14, gap);
                    expect_res($sformatf("rnd%0d_ftr", it), 0, 0, 1);
                end
                default: begin
                    send_bytes(fr, int'($urandom_range(1, 13)), gap);
                    idle(TC + 2);
                    expect_res($sformatf("rnd%0d_to", it), 0, 0, 1);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
